// File: rtl/axi4_sram_slave.sv
// AXI4 responder backed by a word-addressed SRAM. It serves one transaction at a time
// and supports FIXED/INCR/WRAP bursts, byte strobes and ID echo.
//
// state | meaning
// IDLE  | arbitrating AW/AR, no transaction in flight
// WDATA | accepting write beats until beat == len
// WRESP | holding write response until bready
// RDATA | presenting registered read beats until the rlast handshake
module axi4_sram_slave #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter int                ID_W      = 4,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
    parameter int                DEPTH     = 4096
) (
    input  logic              clock,
    input  logic              reset,
    output logic              io_slave_awready,
    input  logic              io_slave_awvalid,
    input  logic [ADDR_W-1:0] io_slave_awaddr,
    input  logic [ID_W-1:0]   io_slave_awid,
    input  logic [7:0]        io_slave_awlen,
    input  logic [2:0]        io_slave_awsize,
    input  logic [1:0]        io_slave_awburst,
    output logic              io_slave_wready,
    input  logic              io_slave_wvalid,
    input  logic [DATA_W-1:0] io_slave_wdata,
    input  logic [3:0]        io_slave_wstrb,
    input  logic              io_slave_wlast,
    input  logic              io_slave_bready,
    output logic              io_slave_bvalid,
    output logic [1:0]        io_slave_bresp,
    output logic [ID_W-1:0]   io_slave_bid,
    output logic              io_slave_arready,
    input  logic              io_slave_arvalid,
    input  logic [ADDR_W-1:0] io_slave_araddr,
    input  logic [ID_W-1:0]   io_slave_arid,
    input  logic [7:0]        io_slave_arlen,
    input  logic [2:0]        io_slave_arsize,
    input  logic [1:0]        io_slave_arburst,
    input  logic              io_slave_rready,
    output logic              io_slave_rvalid,
    output logic [1:0]        io_slave_rresp,
    output logic [DATA_W-1:0] io_slave_rdata,
    output logic              io_slave_rlast,
    output logic [ID_W-1:0]   io_slave_rid
);

    localparam int                IDX_W  = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] SPAN   = ADDR_W'(4 * DEPTH);
    localparam logic [1:0]        OKAY   = 2'b00;
    localparam logic [1:0]        SLVERR = 2'b10;
    localparam logic [1:0]        DECERR = 2'b11;

    typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_t;

    state_t state, state_nx;

    logic [ADDR_W-1:0] addr_q;
    logic [ID_W-1:0]   id_q;
    logic [7:0]        len_q;
    logic [2:0]        size_q;
    logic [1:0]        burst_q;
    logic [7:0]        beat_q;
    logic              berr_q;
    logic [1:0]        resp_q;
    logic              prio_w_q;
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        rresp_q;
    logic              rlast_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              aw_rdy, ar_rdy, w_rdy, b_vld;
    logic              aw_fire, ar_fire, w_fire, r_fire, both_valid;
    logic              aw_bad, ar_bad;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_bad;
    logic [1:0]        rd_resp;
    logic [DATA_W-1:0] rd_word;
    logic [1:0]        w_resp;
    logic              mem_we;
    logic [IDX_W-1:0]  w_idx;

    function automatic logic burst_bad(input logic [7:0] len, input logic [2:0] size,
                                       input logic [1:0] burst);
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (burst == 2'b11) || (size > 3'd2) || ((burst == 2'b10) && !wrap_len_ok);
    endfunction

    // WRAP window is (len+1)<<size bytes; only meaningful for legal power-of-two lengths.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                    input logic [2:0] size,
                                                    input logic [7:0] len,
                                                    input logic [1:0] burst);
        logic [ADDR_W-1:0] step, wmask;
        step  = ADDR_W'(1) << size;
        wmask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        case (burst)
            2'b01:   return a + step;
            2'b10:   return (a & ~wmask) | ((a + step) & wmask);
            default: return a;
        endcase
    endfunction

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (a >= BASE_ADDR) && ((a - BASE_ADDR) < SPAN);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

    assign both_valid = io_slave_awvalid & io_slave_arvalid;
    assign aw_fire    = aw_rdy & io_slave_awvalid;
    assign ar_fire    = ar_rdy & io_slave_arvalid;
    assign w_fire     = w_rdy & io_slave_wvalid;
    assign r_fire     = rvalid_q & io_slave_rready;
    assign aw_bad     = burst_bad(io_slave_awlen, io_slave_awsize, io_slave_awburst);
    assign ar_bad     = burst_bad(io_slave_arlen, io_slave_arsize, io_slave_arburst);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        aw_rdy   = 1'b0;
        ar_rdy   = 1'b0;
        w_rdy    = 1'b0;
        b_vld    = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    aw_rdy = io_slave_awvalid & (!io_slave_arvalid | prio_w_q);
                    ar_rdy = io_slave_arvalid & (!io_slave_awvalid | !prio_w_q);
                    if (aw_rdy)      state_nx = WDATA;
                    else if (ar_rdy) state_nx = RDATA;
                end
                WDATA: begin
                    w_rdy = 1'b1;
                    if (io_slave_wvalid && (beat_q == len_q)) state_nx = WRESP;
                end
                WRESP: begin
                    b_vld = 1'b1;
                    if (io_slave_bready) state_nx = IDLE;
                end
                RDATA: begin
                    if (r_fire && rlast_q) state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // In IDLE the lookup serves the first beat of an incoming AR; otherwise the next beat.
    always_comb begin
        rd_addr = next_addr(addr_q, size_q, len_q, burst_q);
        rd_bad  = berr_q;
        if (state == IDLE) begin
            rd_addr = io_slave_araddr;
            rd_bad  = ar_bad;
        end
        rd_resp = OKAY;
        rd_word = '0;
        if (!in_range(rd_addr))  rd_resp = DECERR;
        else if (rd_bad)         rd_resp = SLVERR;
        else                     rd_word = mem[word_idx(rd_addr)];
    end

    always_comb begin
        w_resp = OKAY;
        if (!in_range(addr_q))
            w_resp = DECERR;
        else if (berr_q || (io_slave_wlast != (beat_q == len_q)))
            w_resp = SLVERR;
        mem_we = w_fire && in_range(addr_q) && !berr_q;
        w_idx  = word_idx(addr_q);
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int b = 0; b < DATA_W / 8; b++)
                if (io_slave_wstrb[b]) mem[w_idx][8*b +: 8] <= io_slave_wdata[8*b +: 8];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q   <= '0;
            id_q     <= '0;
            len_q    <= '0;
            size_q   <= '0;
            burst_q  <= '0;
            beat_q   <= '0;
            berr_q   <= 1'b0;
            resp_q   <= OKAY;
            prio_w_q <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= OKAY;
            rlast_q  <= 1'b0;
        end else begin
            if (aw_fire) begin
                addr_q  <= io_slave_awaddr;
                id_q    <= io_slave_awid;
                len_q   <= io_slave_awlen;
                size_q  <= io_slave_awsize;
                burst_q <= io_slave_awburst;
                beat_q  <= '0;
                berr_q  <= aw_bad;
                resp_q  <= OKAY;
            end
            if (ar_fire) begin
                addr_q   <= io_slave_araddr;
                id_q     <= io_slave_arid;
                len_q    <= io_slave_arlen;
                size_q   <= io_slave_arsize;
                burst_q  <= io_slave_arburst;
                beat_q   <= '0;
                berr_q   <= ar_bad;
                rvalid_q <= 1'b1;
                rdata_q  <= rd_word;
                rresp_q  <= rd_resp;
                rlast_q  <= (io_slave_arlen == 8'd0);
            end
            if ((aw_fire || ar_fire) && both_valid) prio_w_q <= ~prio_w_q;
            if (w_fire) begin
                addr_q <= next_addr(addr_q, size_q, len_q, burst_q);
                beat_q <= beat_q + 8'd1;
                if (w_resp > resp_q) resp_q <= w_resp;
            end
            if (r_fire) begin
                if (rlast_q) begin
                    rvalid_q <= 1'b0;
                    rlast_q  <= 1'b0;
                end else begin
                    addr_q  <= rd_addr;
                    beat_q  <= beat_q + 8'd1;
                    rdata_q <= rd_word;
                    rresp_q <= rd_resp;
                    rlast_q <= ((beat_q + 8'd1) == len_q);
                end
            end
        end
    end

    assign io_slave_awready = aw_rdy;
    assign io_slave_arready = ar_rdy;
    assign io_slave_wready  = w_rdy;
    assign io_slave_bvalid  = b_vld;
    assign io_slave_bresp   = resp_q;
    assign io_slave_bid     = id_q;
    assign io_slave_rvalid  = rvalid_q;
    assign io_slave_rresp   = rresp_q;
    assign io_slave_rdata   = rdata_q;
    assign io_slave_rlast   = rlast_q;
    assign io_slave_rid     = id_q;

endmodule

// File: tb/tb_axi4_sram_slave.sv
// Scoreboard bench for axi4_sram_slave: a word model predicts read beats and write
// responses, which monitors compare against the channels as handshakes occur.
module tb_axi4_sram_slave;

    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        awready, awvalid = 0, wready, wvalid = 0, wlast = 0, bready = 1, bvalid;
    logic        arready, arvalid = 0, rready = 1, rvalid, rlast;
    logic [31:0] awaddr = 0, araddr = 0, wdata = 0, rdata;
    logic [3:0]  awid = 0, arid = 0, bid, rid, wstrb = 0;
    logic [7:0]  awlen = 0, arlen = 0;
    logic [2:0]  awsize = 0, arsize = 0;
    logic [1:0]  awburst = 0, arburst = 0, bresp, rresp;

    always #5 clock = ~clock;

    axi4_sram_slave dut (
        .clock(clock), .reset(reset),
        .io_slave_awready(awready), .io_slave_awvalid(awvalid), .io_slave_awaddr(awaddr),
        .io_slave_awid(awid), .io_slave_awlen(awlen), .io_slave_awsize(awsize),
        .io_slave_awburst(awburst),
        .io_slave_wready(wready), .io_slave_wvalid(wvalid), .io_slave_wdata(wdata),
        .io_slave_wstrb(wstrb), .io_slave_wlast(wlast),
        .io_slave_bready(bready), .io_slave_bvalid(bvalid), .io_slave_bresp(bresp),
        .io_slave_bid(bid),
        .io_slave_arready(arready), .io_slave_arvalid(arvalid), .io_slave_araddr(araddr),
        .io_slave_arid(arid), .io_slave_arlen(arlen), .io_slave_arsize(arsize),
        .io_slave_arburst(arburst),
        .io_slave_rready(rready), .io_slave_rvalid(rvalid), .io_slave_rresp(rresp),
        .io_slave_rdata(rdata), .io_slave_rlast(rlast), .io_slave_rid(rid)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } rbeat_t;

    rbeat_t      rq[$];
    logic [5:0]  bq[$];
    logic [31:0] model [4096];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    bit          rr_random = 0;

    function automatic logic b_bad(input logic [7:0] ln, input logic [2:0] sz, input logic [1:0] bt);
        if (bt == 2'b11 || sz > 3'd2) return 1'b1;
        if (bt == 2'b10 && !(ln == 1 || ln == 3 || ln == 7 || ln == 15)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic b_in(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'd16384);
    endfunction

    function automatic logic [31:0] b_next(input logic [31:0] a, input logic [2:0] sz,
                                          input logic [7:0] ln, input logic [1:0] bt);
        logic [31:0] step, win, lo, n;
        step = 32'd1 << sz;
        n    = a + step;
        if (bt == 2'b00 || bt == 2'b11) return a;
        if (bt == 2'b10) begin
            win = (32'(ln) + 32'd1) * step;
            lo  = a - (a % win);
            if (n >= lo + win) n = lo;
        end
        return n;
    endfunction

    task automatic push_read_exp(input logic [31:0] a, input logic [3:0] id, input logic [7:0] ln,
                                 input logic [2:0] sz, input logic [1:0] bt);
        rbeat_t e;
        logic   bad;
        bad = b_bad(ln, sz, bt);
        for (int i = 0; i <= int'(ln); i++) begin
            e.id   = id;
            e.last = (i == int'(ln));
            if (!b_in(a))  begin e.resp = 2'b11; e.data = 0; end
            else if (bad)  begin e.resp = 2'b10; e.data = 0; end
            else           begin e.resp = 2'b00; e.data = model[int'((a - BASE) >> 2)]; end
            rq.push_back(e);
            a = b_next(a, sz, ln, bt);
        end
    endtask

    task automatic exp_write(input logic [31:0] a, input logic [3:0] id, input logic [7:0] ln,
                             input logic [2:0] sz, input logic [1:0] bt, input int wlb);
        logic [1:0] worst, r;
        logic       bad;
        int         idx;
        worst = 0;
        bad   = b_bad(ln, sz, bt);
        for (int i = 0; i <= int'(ln); i++) begin
            if (!b_in(a))                                  r = 2'b11;
            else if (bad || ((i == wlb) != (i == int'(ln)))) r = 2'b10;
            else                                           r = 2'b00;
            if (b_in(a) && !bad) begin
                idx = int'((a - BASE) >> 2);
                for (int b = 0; b < 4; b++)
                    if (ws[i][b]) model[idx][8*b +: 8] = wd[i][8*b +: 8];
            end
            if (r > worst) worst = r;
            a = b_next(a, sz, ln, bt);
        end
        bq.push_back({id, worst});
    endtask

    // ch: 0 = AW, 1 = W, 2 = AR. Returns just after the handshake edge.
    task automatic wait_ready(input int ch, output bit ok);
        ok = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clock);
            if ((ch == 0 && awready) || (ch == 1 && wready) || (ch == 2 && arready)) begin
                ok = 1;
                break;
            end
        end
        if (ok) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_w(input logic [7:0] ln, input int wlb);
        bit ok;
        for (int i = 0; i <= int'(ln); i++) begin
            wvalid = 1; wdata = wd[i]; wstrb = ws[i]; wlast = (i == wlb);
            wait_ready(1, ok);
            chk("w_hs", ok, 1);
        end
        wvalid = 0; wlast = 0;
    endtask

    task automatic wait_b_drain();
        int n;
        n = 0;
        while (bq.size() != 0 && n < 200) begin @(posedge clock); n++; end
        chk("b_drain", bq.size(), 0);
        #1;
    endtask

    task automatic wait_r_drain(output int n);
        n = 0;
        while (rq.size() != 0 && n < 400) begin @(posedge clock); n++; end
        chk("r_drain", rq.size(), 0);
        #1;
        chk("rvalid_drop", rvalid, 0);
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [3:0] id, input logic [7:0] ln,
                             input logic [2:0] sz, input logic [1:0] bt, input int wlb);
        bit ok;
        exp_write(a, id, ln, sz, bt, wlb);
        awaddr = a; awid = id; awlen = ln; awsize = sz; awburst = bt; awvalid = 1;
        wait_ready(0, ok);
        awvalid = 0;
        chk("aw_hs", ok, 1);
        chk("wready_lat", wready, 1);
        send_w(ln, wlb);
        chk("bvalid_lat", bvalid, 1);
        wait_b_drain();
    endtask

    task automatic axi_read(input logic [31:0] a, input logic [3:0] id, input logic [7:0] ln,
                            input logic [2:0] sz, input logic [1:0] bt);
        bit ok;
        int n;
        push_read_exp(a, id, ln, sz, bt);
        araddr = a; arid = id; arlen = ln; arsize = sz; arburst = bt; arvalid = 1;
        wait_ready(2, ok);
        arvalid = 0;
        chk("ar_hs", ok, 1);
        chk("rvalid_lat", rvalid, 1);
        wait_r_drain(n);
        if (!rr_random) chk("r_cycles", n, int'(ln) + 1);
    endtask

    always @(posedge clock) begin
        #1;
        rready = rr_random ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    rbeat_t     held, mon_e;
    logic [5:0] mon_b;
    bit         stalled = 0;

    always @(negedge clock) begin
        if (reset) begin
            stalled = 0;
        end else begin
            if (rvalid) begin
                if (stalled) chk("r_hold", {rdata, rresp, rlast}, {held.data, held.resp, held.last});
                if (rready) begin
                    stalled = 0;
                    if (rq.size() == 0) chk("r_extra", rvalid, 0);
                    else begin
                        mon_e = rq.pop_front();
                        chk("rdata", rdata, mon_e.data);
                        chk("rresp", rresp, mon_e.resp);
                        chk("rlast", rlast, mon_e.last);
                        chk("rid", rid, mon_e.id);
                    end
                end else begin
                    stalled   = 1;
                    held.data = rdata; held.resp = rresp; held.last = rlast;
                end
            end else begin
                stalled = 0;
            end
            if (bvalid && bready) begin
                if (bq.size() == 0) chk("b_extra", bvalid, 0);
                else begin
                    mon_b = bq.pop_front();
                    chk("bresp", bresp, mon_b[1:0]);
                    chk("bid", bid, mon_b[5:2]);
                end
            end
        end
    end

    initial begin
        bit ok;
        int n;
        for (int i = 0; i < 4096; i++) model[i] = 0;
        for (int i = 0; i < 16; i++) begin wd[i] = 0; ws[i] = 4'hF; end

        // reset values, with both address valids high to show readies are held low
        awvalid = 1; arvalid = 1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_awready", awready, 0);
        chk("rst_arready", arready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rlast", rlast, 0);
        chk("rst_resp", {bresp, rresp}, 0);
        chk("rst_ids", {bid, rid}, 0);
        awvalid = 0; arvalid = 0;
        reset = 0;
        @(posedge clock); #1;

        // single write then read
        wd[0] = 32'hDEAD_BEEF; ws[0] = 4'hF;
        axi_write(32'h8000_0010, 4'h3, 0, 2, 2'b01, 0);
        axi_read(32'h8000_0010, 4'h5, 0, 2, 2'b01);

        // INCR burst
        for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
        axi_write(32'h8000_0100, 4'h1, 3, 2, 2'b01, 3);
        axi_read(32'h8000_0100, 4'h2, 3, 2, 2'b01);

        // WRAP bursts: legal len 3 and illegal len 2
        for (int i = 0; i < 4; i++) wd[i] = 32'hA0 + 32'(i);
        axi_write(32'h8000_0200, 4'h6, 3, 2, 2'b01, 3);
        axi_read(32'h8000_0208, 4'h3, 3, 2, 2'b10);
        axi_read(32'h8000_0208, 4'h4, 2, 2, 2'b10);

        // byte strobes
        wd[0] = 32'h1122_3344; ws[0] = 4'hF;
        axi_write(32'h8000_0300, 4'h7, 0, 2, 2'b01, 0);
        wd[0] = 32'hAABB_CCDD; ws[0] = 4'b0010;
        axi_write(32'h8000_0300, 4'h7, 0, 2, 2'b01, 0);
        ws[0] = 4'hF;
        axi_read(32'h8000_0300, 4'h8, 0, 2, 2'b01);

        // rready backpressure
        rr_random = 1;
        axi_read(32'h8000_0100, 4'h9, 3, 2, 2'b01);
        axi_read(32'h8000_0208, 4'hA, 3, 2, 2'b10);
        rr_random = 0;
        @(posedge clock); #1;

        // decode error leaves SRAM intact; early wlast; illegal burst type
        wd[0] = 32'hCAFE_F00D;
        axi_write(32'h8000_0000, 4'h1, 0, 2, 2'b01, 0);
        wd[0] = 32'h1234_5678;
        axi_write(32'h0000_0000, 4'h2, 0, 2, 2'b01, 0);
        axi_read(32'h8000_0000, 4'h3, 0, 2, 2'b01);
        axi_read(32'h0000_0000, 4'h4, 0, 2, 2'b01);
        for (int i = 0; i < 4; i++) wd[i] = 32'h400 + 32'(i);
        axi_write(32'h8000_0400, 4'h8, 3, 2, 2'b01, 1);
        axi_write(32'h8000_0500, 4'h9, 0, 2, 2'b11, 0);

        // arbitration: read wins the first tie, write the second
        push_read_exp(32'h8000_0010, 4'hA, 0, 2, 2'b01);
        araddr = 32'h8000_0010; arid = 4'hA; arlen = 0; arsize = 2; arburst = 2'b01;
        awaddr = 32'h8000_0700; awid = 4'hB; awlen = 0; awsize = 2; awburst = 2'b01;
        arvalid = 1; awvalid = 1;
        @(negedge clock);
        chk("arb1_ar", arready, 1);
        chk("arb1_aw", awready, 0);
        @(posedge clock); #1;
        arvalid = 0; awvalid = 0;
        wait_r_drain(n);
        wd[0] = 32'h5A5A_0001; ws[0] = 4'hF;
        exp_write(32'h8000_0700, 4'hB, 0, 2, 2'b01, 0);
        arvalid = 1; awvalid = 1;
        @(negedge clock);
        chk("arb2_aw", awready, 1);
        chk("arb2_ar", arready, 0);
        @(posedge clock); #1;
        arvalid = 0; awvalid = 0;
        chk("arb2_wready", wready, 1);
        send_w(0, 0);
        wait_b_drain();
        axi_read(32'h8000_0700, 4'hC, 0, 2, 2'b01);

        // reset during beat 2 of a len 7 read
        for (int i = 0; i < 8; i++) wd[i] = 32'h600 + 32'(i);
        axi_write(32'h8000_0600, 4'h1, 7, 2, 2'b01, 7);
        push_read_exp(32'h8000_0600, 4'h2, 7, 2, 2'b01);
        araddr = 32'h8000_0600; arid = 4'h2; arlen = 7; arsize = 2; arburst = 2'b01; arvalid = 1;
        wait_ready(2, ok);
        arvalid = 0;
        chk("rst_ar_hs", ok, 1);
        n = 0;
        while (rq.size() != 6 && n < 100) begin @(posedge clock); #1; n++; end
        chk("rst_at_beat2", rq.size(), 6);
        reset = 1;
        @(posedge clock); #1;
        chk("rst_mid_rvalid", rvalid, 0);
        rq.delete();
        reset = 0;
        arvalid = 1; araddr = 32'h8000_0600;
        #1;
        chk("rst_arready_hi", arready, 1);
        arvalid = 0;
        #1;
        chk("rst_arready_lo", arready, 0);
        @(posedge clock); #1;
        axi_read(32'h8000_0600, 4'h3, 7, 2, 2'b01);

        chk("rq_empty", rq.size(), 0);
        chk("bq_empty", bq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
